// File: rtl/print_mech_pkg.sv
// Shared types and default widths for the print line capture path.
//   HEAD_WIDTH_DEF  dots per paper line
//   BURN_CNT_W_DEF  width of the per-line burn-cycle count
//   FEED_CNT_W_DEF  width of the blank-line feed count
//   line_entry_t    one completed line as queued towards the analyser
package print_mech_pkg;

  localparam int HEAD_WIDTH_DEF = 384;
  localparam int BURN_CNT_W_DEF = 24;
  localparam int FEED_CNT_W_DEF = 8;

  typedef struct packed {
    logic [HEAD_WIDTH_DEF-1:0] dots;
    logic [BURN_CNT_W_DEF-1:0] burn_cycles;
    logic [FEED_CNT_W_DEF-1:0] feeds;
  } line_entry_t;

endpackage

// File: rtl/line_fifo.sv
// First-word-fall-through FIFO of completed lines.
//   clk, reset     clock, async active-low reset
//   flush          synchronous clear of pointers and level (wins over push/pop)
//   push/push_data write request; accepted when not full or when a pop frees a slot
//   pop/pop_data   read request; pop_data always shows the head slot
//   full/empty     derived from level, which tells full apart from empty
//   level          number of stored lines
module line_fifo
  import print_mech_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  line_entry_t              push_data,
  input  logic                     pop,
  output line_entry_t              pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] DEPTH_LVL = LVL_W'(DEPTH);

  line_entry_t      mem_q [DEPTH];
  line_entry_t      mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             wr_en_s;
  logic             rd_en_s;

  // Status flags and effective read/write enables
  always_comb begin
    full     = (level_q == DEPTH_LVL);
    empty    = (level_q == {LVL_W{1'b0}});
    rd_en_s  = pop && !empty && !flush;
    // A pop in the same cycle frees a slot, so a full FIFO can still accept
    wr_en_s  = push && !flush && (!full || rd_en_s);
    level    = level_q;
    pop_data = mem_q[rd_ptr_q];
  end

  // Next-state for storage, pointers and level
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = {PTR_W{1'b0}};
      rd_ptr_d = {PTR_W{1'b0}};
      level_d  = {LVL_W{1'b0}};
    end else begin
      if (wr_en_s) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (rd_en_s) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({wr_en_s, rd_en_s})
        2'b10:   level_d = level_q + LVL_W'(1);
        2'b01:   level_d = level_q - LVL_W'(1);
        default: level_d = level_q;
      endcase
    end
  end

  // State registers; storage is cleared on reset so outputs start at zero
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      level_q  <= {LVL_W{1'b0}};
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

endmodule

// File: rtl/print_line_buffer.sv
// Line capture stage between the thermal head / stepper and the analyser.
// Qualifies head strobes by minimum length, ORs qualified dots into the open
// line, counts burn cycles, folds blank lines into a feed count and queues
// completed lines in a FIFO drained by valid/ready.
//   clk, reset           clock, async active-low reset
//   enable               0: strobes and ticks ignored (FIFO still drains)
//   flush                synchronous clear of all state
//   head_active(_dots)   strobe and dots from the thermal head
//   line_adv_tick        paper advance pulse; closes the open line
//   line_valid/ready     handshake for the FIFO head
//   line_dots/burn_cycles/feeds  contents of the FIFO head
//   fifo_level           queued line count
//   overflow             sticky: a completed line was dropped on a full FIFO
// The width parameters must stay equal to the print_mech_pkg defaults, since
// line_entry_t is sized from them.
module print_line_buffer
  import print_mech_pkg::*;
#(
  parameter int HEAD_WIDTH = HEAD_WIDTH_DEF,
  parameter int FIFO_DEPTH = 8,
  parameter int MIN_STROBE = 4,
  parameter int BURN_CNT_W = BURN_CNT_W_DEF,
  parameter int FEED_CNT_W = FEED_CNT_W_DEF,
  parameter bit SKIP_BLANK = 1'b1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic                          flush,
  input  logic                          head_active,
  input  logic [HEAD_WIDTH-1:0]         head_active_dots,
  input  logic                          line_adv_tick,
  output logic                          line_valid,
  input  logic                          line_ready,
  output logic [HEAD_WIDTH-1:0]         line_dots,
  output logic [BURN_CNT_W-1:0]         line_burn_cycles,
  output logic [FEED_CNT_W-1:0]         line_feeds,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow
);

  localparam int LEN_W = $clog2(MIN_STROBE + 1);
  localparam logic [LEN_W-1:0] MIN_LEN = LEN_W'(MIN_STROBE);

  function automatic logic [BURN_CNT_W-1:0] burn_sat_add(
    input logic [BURN_CNT_W-1:0] a,
    input logic [BURN_CNT_W-1:0] b
  );
    logic [BURN_CNT_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum[BURN_CNT_W]) begin
      return {BURN_CNT_W{1'b1}};
    end else begin
      return sum[BURN_CNT_W-1:0];
    end
  endfunction

  function automatic logic [FEED_CNT_W-1:0] feed_sat_inc(input logic [FEED_CNT_W-1:0] a);
    if (a == {FEED_CNT_W{1'b1}}) begin
      return a;
    end else begin
      return a + FEED_CNT_W'(1);
    end
  endfunction

  logic [HEAD_WIDTH-1:0] strobe_dots_q, strobe_dots_d;
  logic [LEN_W-1:0]      strobe_len_q, strobe_len_d;
  logic [BURN_CNT_W-1:0] strobe_total_q, strobe_total_d;
  logic [HEAD_WIDTH-1:0] burn_line_q, burn_line_d;
  logic [BURN_CNT_W-1:0] burn_cnt_q, burn_cnt_d;
  logic [FEED_CNT_W-1:0] feed_cnt_q, feed_cnt_d;
  logic                  push_q, push_d;
  line_entry_t           push_entry_q, push_entry_d;
  logic                  overflow_q, overflow_d;

  logic                  credit_s;
  logic [HEAD_WIDTH-1:0] close_dots_s;
  logic [BURN_CNT_W-1:0] close_cnt_s;
  logic                  pop_s;
  logic                  fifo_full_s;
  logic                  fifo_empty_s;
  line_entry_t           head_s;

  // Line contents as they stand at this edge, including a strobe ending now
  always_comb begin
    // strobe_total is nonzero exactly while a strobe is open
    credit_s = enable && !head_active && (strobe_total_q != {BURN_CNT_W{1'b0}})
               && (strobe_len_q == MIN_LEN);
    if (credit_s) begin
      close_dots_s = burn_line_q | strobe_dots_q;
      close_cnt_s  = burn_sat_add(burn_cnt_q, strobe_total_q);
    end else begin
      close_dots_s = burn_line_q;
      close_cnt_s  = burn_cnt_q;
    end
  end

  // Strobe tracking, line accumulation, blank folding and push staging
  always_comb begin
    strobe_dots_d  = strobe_dots_q;
    strobe_len_d   = strobe_len_q;
    strobe_total_d = strobe_total_q;
    burn_line_d    = burn_line_q;
    burn_cnt_d     = burn_cnt_q;
    feed_cnt_d     = feed_cnt_q;
    push_d         = 1'b0;
    push_entry_d   = push_entry_q;
    overflow_d     = overflow_q;
    if (flush) begin
      strobe_dots_d  = {HEAD_WIDTH{1'b0}};
      strobe_len_d   = {LEN_W{1'b0}};
      strobe_total_d = {BURN_CNT_W{1'b0}};
      burn_line_d    = {HEAD_WIDTH{1'b0}};
      burn_cnt_d     = {BURN_CNT_W{1'b0}};
      feed_cnt_d     = {FEED_CNT_W{1'b0}};
      push_d         = 1'b0;
      overflow_d     = 1'b0;
    end else begin
      // Any cycle without an enabled strobe ends or discards the open one;
      // a qualifying end has already been folded into close_* above.
      if (enable && head_active) begin
        strobe_dots_d  = strobe_dots_q | head_active_dots;
        strobe_len_d   = (strobe_len_q == MIN_LEN) ? strobe_len_q : strobe_len_q + LEN_W'(1);
        strobe_total_d = burn_sat_add(strobe_total_q, BURN_CNT_W'(1));
      end else begin
        strobe_dots_d  = {HEAD_WIDTH{1'b0}};
        strobe_len_d   = {LEN_W{1'b0}};
        strobe_total_d = {BURN_CNT_W{1'b0}};
      end

      if (enable && line_adv_tick) begin
        burn_line_d = {HEAD_WIDTH{1'b0}};
        burn_cnt_d  = {BURN_CNT_W{1'b0}};
        if (SKIP_BLANK && (close_dots_s == {HEAD_WIDTH{1'b0}})) begin
          feed_cnt_d = feed_sat_inc(feed_cnt_q);
        end else begin
          push_d                   = 1'b1;
          push_entry_d.dots        = close_dots_s;
          push_entry_d.burn_cycles = close_cnt_s;
          push_entry_d.feeds       = feed_cnt_q;
          feed_cnt_d               = {FEED_CNT_W{1'b0}};
        end
      end else begin
        burn_line_d = close_dots_s;
        burn_cnt_d  = close_cnt_s;
      end

      // The staged push is dropped when the FIFO is full and nothing leaves
      if (push_q && fifo_full_s && !pop_s) begin
        overflow_d = 1'b1;
      end else begin
        overflow_d = overflow_q;
      end
    end
  end

  // State registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      strobe_dots_q  <= {HEAD_WIDTH{1'b0}};
      strobe_len_q   <= {LEN_W{1'b0}};
      strobe_total_q <= {BURN_CNT_W{1'b0}};
      burn_line_q    <= {HEAD_WIDTH{1'b0}};
      burn_cnt_q     <= {BURN_CNT_W{1'b0}};
      feed_cnt_q     <= {FEED_CNT_W{1'b0}};
      push_q         <= 1'b0;
      push_entry_q   <= '0;
      overflow_q     <= 1'b0;
    end else begin
      strobe_dots_q  <= strobe_dots_d;
      strobe_len_q   <= strobe_len_d;
      strobe_total_q <= strobe_total_d;
      burn_line_q    <= burn_line_d;
      burn_cnt_q     <= burn_cnt_d;
      feed_cnt_q     <= feed_cnt_d;
      push_q         <= push_d;
      push_entry_q   <= push_entry_d;
      overflow_q     <= overflow_d;
    end
  end

  line_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_line_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .push      (push_q),
    .push_data (push_entry_q),
    .pop       (pop_s),
    .pop_data  (head_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .level     (fifo_level)
  );

  // Handshake and head-of-queue outputs
  always_comb begin
    line_valid       = !fifo_empty_s;
    pop_s            = line_ready && !fifo_empty_s;
    line_dots        = head_s.dots;
    line_burn_cycles = head_s.burn_cycles;
    line_feeds       = head_s.feeds;
    overflow         = overflow_q;
  end

endmodule

// File: tb/tb_print_line_buffer.sv
module tb_print_line_buffer;

  logic         clk;
  logic         reset;
  logic         enable;
  logic         flush;
  logic         head_active;
  logic [383:0] head_active_dots;
  logic         line_adv_tick;
  logic         line_valid;
  logic         line_ready;
  logic [383:0] line_dots;
  logic [23:0]  line_burn_cycles;
  logic [7:0]   line_feeds;
  logic [3:0]   fifo_level;
  logic         overflow;

  int checks = 0;
  int errors = 0;

  print_line_buffer dut (
    .clk              (clk),
    .reset            (reset),
    .enable           (enable),
    .flush            (flush),
    .head_active      (head_active),
    .head_active_dots (head_active_dots),
    .line_adv_tick    (line_adv_tick),
    .line_valid       (line_valid),
    .line_ready       (line_ready),
    .line_dots        (line_dots),
    .line_burn_cycles (line_burn_cycles),
    .line_feeds       (line_feeds),
    .fifo_level       (fifo_level),
    .overflow         (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int           len;
    logic [383:0] dots;
    bit           queued;
    logic [23:0]  burn;
    logic [7:0]   feeds;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input logic [383:0] act, input logic [383:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [383:0] mk_dots(input int k);
    logic [383:0] d;
    d = 384'(k + 1);
    return d << (k * 40);
  endfunction

  // Strobe of len cycles, then one idle cycle on which it ends
  task automatic strobe(input int len, input logic [383:0] d);
    for (int i = 0; i < len; i++) begin
      head_active = 1'b1;
      head_active_dots = d;
      @(negedge clk);
    end
    head_active = 1'b0;
    head_active_dots = '0;
    @(negedge clk);
  endtask

  task automatic tick();
    line_adv_tick = 1'b1;
    @(negedge clk);
    line_adv_tick = 1'b0;
  endtask

  task automatic run_line(input int len, input logic [383:0] d);
    strobe(len, d);
    tick();
    @(negedge clk);
  endtask

  task automatic pop_expect(input string nm, input logic [383:0] d, input logic [23:0] b,
                            input logic [7:0] f);
    chk({nm, "_valid"}, 384'(line_valid), 384'(1));
    chk({nm, "_dots"}, line_dots, d);
    chk({nm, "_burn"}, 384'(line_burn_cycles), 384'(b));
    chk({nm, "_feeds"}, 384'(line_feeds), 384'(f));
    line_ready = 1'b1;
    @(negedge clk);
    line_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    enable = 1'b1;
    flush = 1'b0;
    head_active = 1'b0;
    head_active_dots = '0;
    line_adv_tick = 1'b0;
    line_ready = 1'b0;

    vecs[0] = '{5, 384'h1,    1'b1, 24'd5, 8'd0};
    vecs[1] = '{3, 384'hF0,   1'b0, 24'd0, 8'd0};
    vecs[2] = '{4, 384'hAA,   1'b1, 24'd4, 8'd1};
    vecs[3] = '{1, 384'h3,    1'b0, 24'd0, 8'd0};
    vecs[4] = '{0, 384'h0,    1'b0, 24'd0, 8'd0};
    vecs[5] = '{7, 384'h0,    1'b1, 24'd7, 8'd2};
    vecs[5].dots[383] = 1'b1;
    vecs[6] = '{2, 384'hFFFF, 1'b0, 24'd0, 8'd0};
    vecs[7] = '{6, 384'h5,    1'b1, 24'd6, 8'd1};

    repeat (3) @(negedge clk);
    chk("rst_valid", 384'(line_valid), 384'(0));
    chk("rst_level", 384'(fifo_level), 384'(0));
    chk("rst_overflow", 384'(overflow), 384'(0));
    chk("rst_dots", line_dots, 384'(0));
    chk("rst_burn", 384'(line_burn_cycles), 384'(0));
    chk("rst_feeds", 384'(line_feeds), 384'(0));
    reset = 1'b1;
    @(negedge clk);

    // Single-line vectors: latency, qualification, blank folding
    for (int i = 0; i < 8; i++) begin
      strobe(vecs[i].len, vecs[i].dots);
      tick();
      chk($sformatf("vec%0d_not_yet_valid", i), 384'(line_valid), 384'(0));
      @(negedge clk);
      if (vecs[i].queued) begin
        chk($sformatf("vec%0d_level", i), 384'(fifo_level), 384'(1));
        pop_expect($sformatf("vec%0d", i), vecs[i].dots, vecs[i].burn, vecs[i].feeds);
      end else begin
        chk($sformatf("vec%0d_blank_level", i), 384'(fifo_level), 384'(0));
        chk($sformatf("vec%0d_blank_valid", i), 384'(line_valid), 384'(0));
      end
    end

    // Overflow: nine lines into eight slots with the consumer stalled
    for (int k = 0; k < 9; k++) begin
      run_line(4 + k, mk_dots(k));
    end
    chk("ovf_level", 384'(fifo_level), 384'(8));
    chk("ovf_flag", 384'(overflow), 384'(1));
    for (int s = 0; s < 3; s++) begin
      chk($sformatf("stall%0d_dots", s), line_dots, mk_dots(0));
      chk($sformatf("stall%0d_burn", s), 384'(line_burn_cycles), 384'(4));
      @(negedge clk);
    end
    for (int k = 0; k < 8; k++) begin
      pop_expect($sformatf("drain%0d", k), mk_dots(k), 24'(4 + k), 8'd0);
    end
    chk("drain_empty", 384'(line_valid), 384'(0));
    chk("drain_ovf_sticky", 384'(overflow), 384'(1));

    // Flush with queued lines, a pending feed and a partly burned line
    tick();
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      run_line(4, mk_dots(k));
    end
    tick();
    @(negedge clk);
    strobe(4, 384'hF00);
    chk("preflush_level", 384'(fifo_level), 384'(3));
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_valid", 384'(line_valid), 384'(0));
    chk("flush_level", 384'(fifo_level), 384'(0));
    chk("flush_overflow", 384'(overflow), 384'(0));
    run_line(4, 384'h10);
    pop_expect("post_flush", 384'h10, 24'd4, 8'd0);

    // Full FIFO with push and pop on the same edge
    for (int k = 0; k < 8; k++) begin
      run_line(4 + k, mk_dots(k));
    end
    chk("full_level", 384'(fifo_level), 384'(8));
    strobe(5, 384'hABC);
    tick();
    line_ready = 1'b1;
    @(negedge clk);
    line_ready = 1'b0;
    chk("fullpop_level", 384'(fifo_level), 384'(8));
    chk("fullpop_overflow", 384'(overflow), 384'(0));
    for (int k = 1; k < 8; k++) begin
      pop_expect($sformatf("fp_drain%0d", k), mk_dots(k), 24'(4 + k), 8'd0);
    end
    pop_expect("fp_last", 384'hABC, 24'd5, 8'd0);

    // Strobe spanning a tick is credited whole to the following line
    head_active = 1'b1;
    head_active_dots = 384'h77;
    @(negedge clk);
    @(negedge clk);
    line_adv_tick = 1'b1;
    @(negedge clk);
    line_adv_tick = 1'b0;
    @(negedge clk);
    @(negedge clk);
    head_active = 1'b0;
    head_active_dots = '0;
    @(negedge clk);
    chk("span_blank_level", 384'(fifo_level), 384'(0));
    tick();
    @(negedge clk);
    pop_expect("span", 384'h77, 24'd5, 8'd1);

    // enable low discards the open strobe and ignores a tick
    head_active = 1'b1;
    head_active_dots = 384'h3;
    repeat (3) @(negedge clk);
    enable = 1'b0;
    line_adv_tick = 1'b1;
    @(negedge clk);
    enable = 1'b1;
    line_adv_tick = 1'b0;
    head_active_dots = 384'hC0;
    repeat (4) @(negedge clk);
    head_active = 1'b0;
    head_active_dots = '0;
    @(negedge clk);
    chk("dis_level", 384'(fifo_level), 384'(0));
    tick();
    @(negedge clk);
    pop_expect("dis", 384'hC0, 24'd4, 8'd0);

    // Async reset mid-strobe with a queued line and partial state
    run_line(4, 384'h1);
    tick();
    @(negedge clk);
    strobe(4, 384'h100);
    head_active = 1'b1;
    head_active_dots = 384'hF000;
    @(negedge clk);
    @(negedge clk);
    chk("prerst_valid", 384'(line_valid), 384'(1));
    #2 reset = 1'b0;
    #1;
    chk("midrst_valid", 384'(line_valid), 384'(0));
    chk("midrst_level", 384'(fifo_level), 384'(0));
    chk("midrst_overflow", 384'(overflow), 384'(0));
    chk("midrst_dots", line_dots, 384'(0));
    head_active = 1'b0;
    head_active_dots = '0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    run_line(4, 384'h2);
    pop_expect("post_rst", 384'h2, 24'd4, 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
